// File: rtl/wide_add_pkg.sv
// Shared types and constants for the multi-precision add sequencer.
//   SLICE_W : width of one adder slice word (fixed at 16)
//   state_t : sequencer FSM states
//   word_t  : one slice-width word
package wide_add_pkg;

    localparam int unsigned SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef logic [SLICE_W-1:0] word_t;

endpackage

// File: rtl/add16_slice.sv
// 16-bit parallel-prefix (Kogge-Stone) adder slice with carry-in.
// Purely combinational.
// Ports:
//   a, b : addend words
//   cin  : carry into bit 0
//   sum  : a + b + cin, low 16 bits
//   cout : carry out of bit 15
//   c15  : carry into bit 15 (used for signed overflow detection)
module add16_slice
    import wide_add_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  logic  cin,
    output word_t sum,
    output logic  cout,
    output logic  c15
);

    // Returns {carry out of bit 15 .. carry out of bit 0, cin}, i.e. bit i is the carry into bit i.
    // cin is folded into the bit-0 generate so the prefix tree needs no extra column.
    function automatic logic [SLICE_W:0] prefix_carries(input word_t g_in, input word_t p_in,
                                                        input logic c_in);
        word_t g;
        word_t p;
        word_t g_n;
        word_t p_n;
        g    = g_in;
        p    = p_in;
        g[0] = g_in[0] | (p_in[0] & c_in);
        for (int d = 1; d < int'(SLICE_W); d = d * 2) begin
            g_n = g;
            p_n = p;
            for (int i = d; i < int'(SLICE_W); i++) begin
                g_n[i] = g[i] | (p[i] & g[i-d]);
                p_n[i] = p[i] & p[i-d];
            end
            g = g_n;
            p = p_n;
        end
        return {g, c_in};
    endfunction

    word_t              prop;
    logic [SLICE_W:0]   carry;

    assign prop  = a ^ b;
    assign carry = prefix_carries(a & b, prop, cin);
    assign sum   = prop ^ carry[SLICE_W-1:0];
    assign cout  = carry[SLICE_W];
    assign c15   = carry[SLICE_W-1];

endmodule

// File: rtl/wide_add_seq.sv
// Multi-precision add sequencer. Accepts a WORDS*16-bit operand pair, pushes it through a single
// 16-bit prefix adder slice one word per cycle (LSW first, carry registered between words) and
// returns the assembled result over a valid/ready handshake.
// Optional feature macro: WIDE_ADD_SUB_EN adds in_sub, selecting A-B instead of A+B.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : operand handshake; in_a, in_b sampled on the accept edge
//   in_sub              : (WIDE_ADD_SUB_EN only) subtract, sampled with the operands
//   out_valid/out_ready : result handshake
//   out_sum             : A+B (or A-B) modulo 2^(WORDS*16)
//   out_cout            : carry out of the MSB (for subtract: 1 = no borrow)
//   out_ovf             : signed overflow
//   busy                : high while a job is running or its result is pending
module wide_add_seq #(
    parameter int unsigned WORDS   = 4,
    parameter int unsigned SLICE_W = 16   // must stay 16: the slice is hard-wired to this width
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORDS*SLICE_W-1:0] in_a,
    input  logic [WORDS*SLICE_W-1:0] in_b,
`ifdef WIDE_ADD_SUB_EN
    input  logic                     in_sub,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORDS*SLICE_W-1:0] out_sum,
    output logic                     out_cout,
    output logic                     out_ovf,
    output logic                     busy
);

    import wide_add_pkg::*;

    localparam int unsigned W     = WORDS * SLICE_W;
    localparam int unsigned IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             sub_q;
    logic             cin0;
    logic             accept;

    word_t            s_a, s_b, s_sum;
    logic             s_cout, s_c15;

`ifdef WIDE_ADD_SUB_EN
    // Subtract as A + ~B + 1: the +1 enters through the initial carry.
    assign cin0 = in_sub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else if (accept) begin
            sub_q <= in_sub;
        end
    end
`else
    assign cin0  = 1'b0;
    assign sub_q = 1'b0;
`endif

    assign accept = in_valid && in_ready;

    assign s_a = a_q[idx_q*SLICE_W +: SLICE_W];
    assign s_b = b_q[idx_q*SLICE_W +: SLICE_W] ^ {SLICE_W{sub_q}};

    add16_slice u_slice (
        .a    (s_a),
        .b    (s_b),
        .cin  (carry_q),
        .sum  (s_sum),
        .cout (s_cout),
        .c15  (s_c15)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    idx_d   = '0;
                    carry_d = cin0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*SLICE_W +: SLICE_W] = s_sum;
                if (idx_q == LAST_IDX) begin
                    // Top word: carries become flags instead of feeding a next word.
                    cout_d  = s_cout;
                    ovf_d   = s_c15 ^ s_cout;
                    state_d = DONE;
                end else begin
                    carry_d = s_cout;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule
